// File: rtl/rx_frame_pkg.sv
// Shared definitions for the bus receive frame parser.
//   - rx_state_t : parser FSM states; each state names the byte it expects next
//                  (IDLE expects ID_L)
//   - RW_*       : RW byte command codes
//   - ERR_*      : frm_err_code values
//   - CRC_*      : CRC-16/MODBUS seed and reflected polynomial
package rx_frame_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ID_H,
      ST_LEN_L,
      ST_LEN_H,
      ST_SID,
      ST_RW,
      ST_DATA,
      ST_CRC_L,
      ST_CRC_H,
      ST_SKIP
   } rx_state_t;

   localparam logic [7:0] RW_READ  = 8'h03;
   localparam logic [7:0] RW_WRITE = 8'h06;

   localparam logic [1:0] ERR_BAD_RW  = 2'd0;
   localparam logic [1:0] ERR_BAD_LEN = 2'd1;
   localparam logic [1:0] ERR_BAD_CRC = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'hA001;

endpackage

// File: rtl/rx_frame_parser_if.sv
// Byte-stream input and command/error outputs of the frame parser.
//   rx_flag/rx_data            : byte strobe and byte from the bus receiver
//   ret_cmd/ret_cmd_flg        : sensor ID to read back, with one-cycle pulse
//   sen_cmd/sen_cmd_flag       : {sensor ID, payload}, with one-cycle pulse
//   frm_err/frm_err_code       : rejected-frame pulse and held reason code
// Modports: master = byte source / command sink, slave = parser.
interface rx_frame_parser_if #(
   parameter int DATA_BYTES = 4
);
   logic                      rx_flag;
   logic [7:0]                rx_data;
   logic [7:0]                ret_cmd;
   logic                      ret_cmd_flg;
   logic [8+8*DATA_BYTES-1:0] sen_cmd;
   logic                      sen_cmd_flag;
   logic                      frm_err;
   logic [1:0]                frm_err_code;

   modport master (
      output rx_flag, rx_data,
      input  ret_cmd, ret_cmd_flg, sen_cmd, sen_cmd_flag, frm_err, frm_err_code
   );

   modport slave (
      input  rx_flag, rx_data,
      output ret_cmd, ret_cmd_flg, sen_cmd, sen_cmd_flag, frm_err, frm_err_code
   );
endinterface

// File: rtl/crc16_modbus_byte.sv
// Combinational CRC-16/MODBUS update for one byte (LSB-first, reflected poly).
//   crc_in  : running CRC before this byte
//   data_in : byte to fold in
//   crc_out : running CRC after this byte
// Only built when RX_FRAME_CRC_CHECK_EN is defined.
module crc16_modbus_byte
   import rx_frame_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);
   always_comb begin
      crc_out = crc_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++) begin
         if (crc_out[0])
            crc_out = (crc_out >> 1) ^ CRC_POLY;
         else
            crc_out = crc_out >> 1;
      end
   end
endmodule

// File: rtl/rx_frame_parser.sv
// Receive frame parser: extracts sensor read/write commands addressed to
// this node from the bus receiver byte stream.
// Frame: ID_L ID_H LEN_L LEN_H SID RW D0..D(N-1) CRC_L CRC_H (little-endian).
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   bus (slave)      : rx_flag/rx_data in; ret_cmd*, sen_cmd*, frm_err* out
// Optional: RX_FRAME_CRC_CHECK_EN builds the CRC-16/MODBUS check; without it
// the CRC bytes are consumed and ignored.
module rx_frame_parser
   import rx_frame_pkg::*;
#(
   parameter logic [15:0] NODE_ID    = 16'h0001,
   parameter int          DATA_BYTES = 4,
   parameter int          GAP_CYCLES = 50000,
   parameter logic [15:0] BCAST_ID   = 16'hFFFF
) (
   input logic          sys_clk,
   input logic          sys_rst,
   rx_frame_parser_if.slave bus
);
   localparam logic [15:0] LEN_OK   = 16'(DATA_BYTES + 4);
   localparam logic [2:0]  LAST_IDX = 3'(DATA_BYTES - 1);
   localparam logic [31:0] GAP_LIM  = 32'(GAP_CYCLES);
   localparam int          PAY_W    = 8 * DATA_BYTES;

   rx_state_t         state, state_nxt;
   logic [15:0]       id_q;
   logic [7:0]        len_lo_q;
   logic [15:0]       len_full;
   logic [15:0]       skip_cnt_q;
   logic [7:0]        sid_q;
   logic              rd_q;
   logic              rw_bad_q;
   logic [2:0]        idx_q;
   logic [PAY_W-1:0]  pay_q;
   logic [31:0]       gap_cnt_q;
   logic [31:0]       gap_nxt;
   logic              addr_own;
   logic              addr_hit;
   logic              crc_ok;
   logic              fire_rd;
   logic              fire_wr;
   logic              fire_err;
   logic [1:0]        err_code_nxt;

   assign len_full = {bus.rx_data, len_lo_q};
   assign addr_own = (id_q == NODE_ID);
   assign addr_hit = addr_own || (id_q == BCAST_ID);
   assign gap_nxt  = gap_cnt_q + 32'd1;

`ifdef RX_FRAME_CRC_CHECK_EN
   logic [15:0] crc_q;
   logic [15:0] crc_in;
   logic [15:0] crc_upd;
   logic [7:0]  crc_lo_q;

   // Seed from CRC_INIT on the first byte so every frame starts clean.
   assign crc_in = (state == ST_IDLE) ? CRC_INIT : crc_q;

   crc16_modbus_byte u_crc (
      .crc_in  (crc_in),
      .data_in (bus.rx_data),
      .crc_out (crc_upd)
   );

   always_ff @(posedge sys_clk) begin
      if (bus.rx_flag) begin
         if (state inside {ST_IDLE, ST_ID_H, ST_LEN_L, ST_LEN_H, ST_SID, ST_RW, ST_DATA})
            crc_q <= crc_upd;
         if (state == ST_CRC_L)
            crc_lo_q <= bus.rx_data;
      end
   end

   assign crc_ok = ({bus.rx_data, crc_lo_q} == crc_q);
`else
   assign crc_ok = 1'b1;
`endif

   // State register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state and completion decisions
   always_comb begin
      state_nxt    = state;
      fire_rd      = 1'b0;
      fire_wr      = 1'b0;
      fire_err     = 1'b0;
      err_code_nxt = ERR_BAD_RW;
      if (bus.rx_flag) begin
         case (state)
            ST_IDLE:  state_nxt = ST_ID_H;
            ST_ID_H:  state_nxt = ST_LEN_L;
            ST_LEN_L: state_nxt = ST_LEN_H;
            ST_LEN_H: begin
               if (!addr_hit) begin
                  // Foreign frame: drop quietly but stay byte-aligned.
                  state_nxt = (len_full == 16'd0) ? ST_IDLE : ST_SKIP;
               end else if (len_full != LEN_OK) begin
                  fire_err     = 1'b1;
                  err_code_nxt = ERR_BAD_LEN;
                  state_nxt    = (len_full == 16'd0) ? ST_IDLE : ST_SKIP;
               end else begin
                  state_nxt = ST_SID;
               end
            end
            ST_SID:   state_nxt = ST_RW;
            ST_RW:    state_nxt = ST_DATA;
            ST_DATA:  state_nxt = (idx_q == LAST_IDX) ? ST_CRC_L : ST_DATA;
            ST_CRC_L: state_nxt = ST_CRC_H;
            ST_CRC_H: begin
               state_nxt = ST_IDLE;
               if (!crc_ok) begin
                  fire_err     = 1'b1;
                  err_code_nxt = ERR_BAD_CRC;
               end else if (rw_bad_q) begin
                  fire_err     = 1'b1;
                  err_code_nxt = ERR_BAD_RW;
               end else if (rd_q) begin
                  // Broadcast reads have no single responder; drop them.
                  fire_rd = addr_own;
               end else begin
                  fire_wr = 1'b1;
               end
            end
            ST_SKIP:  state_nxt = (skip_cnt_q == 16'd1) ? ST_IDLE : ST_SKIP;
            default:  state_nxt = ST_IDLE;
         endcase
      end else if (state != ST_IDLE && gap_nxt == GAP_LIM) begin
         // A byte in the expiry cycle takes the branch above instead.
         state_nxt    = ST_IDLE;
         fire_err     = 1'b1;
         err_code_nxt = ERR_TIMEOUT;
      end
   end

   // Frame field capture
   always_ff @(posedge sys_clk) begin
      if (bus.rx_flag) begin
         case (state)
            ST_IDLE:  id_q[7:0]  <= bus.rx_data;
            ST_ID_H:  id_q[15:8] <= bus.rx_data;
            ST_LEN_L: len_lo_q   <= bus.rx_data;
            ST_LEN_H: skip_cnt_q <= len_full;
            ST_SID:   sid_q      <= bus.rx_data;
            ST_RW: begin
               rd_q     <= (bus.rx_data == RW_READ);
               rw_bad_q <= (bus.rx_data != RW_READ) && (bus.rx_data != RW_WRITE);
               idx_q    <= 3'd0;
            end
            ST_DATA: begin
               pay_q[{idx_q, 3'b000} +: 8] <= bus.rx_data;
               idx_q <= idx_q + 3'd1;
            end
            ST_SKIP:  skip_cnt_q <= skip_cnt_q - 16'd1;
            default: ;
         endcase
      end
   end

   // Gap counter and registered outputs
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         gap_cnt_q        <= '0;
         bus.ret_cmd      <= '0;
         bus.ret_cmd_flg  <= 1'b0;
         bus.sen_cmd      <= '0;
         bus.sen_cmd_flag <= 1'b0;
         bus.frm_err      <= 1'b0;
         bus.frm_err_code <= '0;
      end else begin
         gap_cnt_q        <= (bus.rx_flag || state_nxt == ST_IDLE) ? 32'd0 : gap_nxt;
         bus.ret_cmd_flg  <= fire_rd;
         bus.sen_cmd_flag <= fire_wr;
         bus.frm_err      <= fire_err;
         if (fire_rd)
            bus.ret_cmd <= sid_q;
         if (fire_wr)
            bus.sen_cmd <= {sid_q, pay_q};
         if (fire_err)
            bus.frm_err_code <= err_code_nxt;
      end
   end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Bench for rx_frame_parser: directed frames, expected responses queued by
// the stimulus and checked by an independent output monitor.
module tb_rx_frame_parser;

   localparam int GAP = 10;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   last_e = 0;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   rx_frame_parser_if #(.DATA_BYTES(4)) dut_if ();

   rx_frame_parser #(
      .NODE_ID    (16'h0001),
      .DATA_BYTES (4),
      .GAP_CYCLES (GAP),
      .BCAST_ID   (16'hFFFF)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (dut_if.slave)
   );

   localparam logic [2:0] K_RET = 3'b001;
   localparam logic [2:0] K_SEN = 3'b010;
   localparam logic [2:0] K_ERR = 3'b100;

   typedef struct {
      logic [2:0]  kind;
      logic [39:0] data;
      int          at;
      string       name;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fb[$];

   task automatic expect_out(input logic [2:0] k, input logic [39:0] d,
                             input int at, input string n);
      exp_t e;
      e.kind = k;
      e.data = d;
      e.at   = at;
      e.name = n;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string n, input logic [39:0] act, input logic [39:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s actual=%h required=%h", n, act, req);
      end
   endtask

   function automatic logic [15:0] crc_model(input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, fb[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   task automatic build_frame(input logic [15:0] id, input logic [15:0] len,
                              input logic [7:0] sid, input logic [7:0] rw,
                              input logic [31:0] dat, input bit corrupt);
      logic [15:0] c;
      fb.delete();
      fb.push_back(id[7:0]);
      fb.push_back(id[15:8]);
      fb.push_back(len[7:0]);
      fb.push_back(len[15:8]);
      fb.push_back(sid);
      fb.push_back(rw);
      for (int i = 0; i < 4; i++)
         fb.push_back(dat[8*i +: 8]);
      c = crc_model(10);
      fb.push_back(corrupt ? (c[7:0] ^ 8'h01) : c[7:0]);
      fb.push_back(c[15:8]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      dut_if.rx_flag = 1'b1;
      dut_if.rx_data = b;
      @(posedge sys_clk);
      #1;
      last_e = cyc;
      dut_if.rx_flag = 1'b0;
      dut_if.rx_data = 8'h00;
   endtask

   task automatic send_range(input int from, input int to);
      for (int i = from; i <= to; i++)
         send_byte(fb[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Output monitor
   logic [2:0]  mon_kind;
   logic [39:0] mon_data;
   exp_t        mon_e;

   always @(negedge sys_clk) begin
      if (!sys_rst && (dut_if.ret_cmd_flg || dut_if.sen_cmd_flag || dut_if.frm_err)) begin
         mon_kind = {dut_if.frm_err, dut_if.sen_cmd_flag, dut_if.ret_cmd_flg};
         mon_data = '0;
         if (mon_kind == K_RET)      mon_data = {32'h0, dut_if.ret_cmd};
         else if (mon_kind == K_SEN) mon_data = dut_if.sen_cmd;
         else if (mon_kind == K_ERR) mon_data = {38'h0, dut_if.frm_err_code};
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_output kind=%b data=%h cycle=%0d", mon_kind, mon_data, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_kind !== mon_e.kind || mon_data !== mon_e.data || cyc != mon_e.at) begin
               mismatched++;
               $display("FAIL %s actual kind=%b data=%h cycle=%0d required kind=%b data=%h cycle=%0d",
                        mon_e.name, mon_kind, mon_data, cyc, mon_e.kind, mon_e.data, mon_e.at);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      dut_if.rx_flag = 1'b0;
      dut_if.rx_data = 8'h00;
      sys_rst = 1'b1;
      idle(3);
      chk("reset_ret_cmd",      {32'h0, dut_if.ret_cmd}, 40'h0);
      chk("reset_ret_cmd_flg",  {39'h0, dut_if.ret_cmd_flg}, 40'h0);
      chk("reset_sen_cmd",      dut_if.sen_cmd, 40'h0);
      chk("reset_sen_cmd_flag", {39'h0, dut_if.sen_cmd_flag}, 40'h0);
      chk("reset_frm_err",      {39'h0, dut_if.frm_err}, 40'h0);
      chk("reset_frm_err_code", {38'h0, dut_if.frm_err_code}, 40'h0);
      sys_rst = 1'b0;
      idle(2);

      // Write to own node
      build_frame(16'h0001, 16'h0008, 8'h2A, 8'h06, 32'h44332211, 1'b0);
      send_range(0, 11);
      expect_out(K_SEN, 40'h2A_44332211, last_e, "own_write");
      idle(3);

      // Read to own node
      build_frame(16'h0001, 16'h0008, 8'h05, 8'h03, 32'h00000000, 1'b0);
      send_range(0, 11);
      expect_out(K_RET, 40'h05, last_e, "own_read");
      idle(3);

      // Foreign frame, then own frame
      fb = '{8'h02, 8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      send_range(0, 6);
      build_frame(16'h0001, 16'h0008, 8'h07, 8'h03, 32'hDEADBEEF, 1'b0);
      send_range(0, 11);
      expect_out(K_RET, 40'h07, last_e, "read_after_foreign");
      idle(3);

      // Bad length, 5 bytes skipped, then good write
      fb = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h06, 8'h06, 8'h01, 8'h02, 8'h03};
      send_range(0, 3);
      expect_out(K_ERR, 40'd1, last_e, "bad_len");
      send_range(4, 8);
      build_frame(16'h0001, 16'h0008, 8'h11, 8'h06, 32'hA5A5_5A5A, 1'b0);
      send_range(0, 11);
      expect_out(K_SEN, 40'h11_A5A55A5A, last_e, "write_after_bad_len");
      idle(3);

      // Bad RW with correct CRC
      build_frame(16'h0001, 16'h0008, 8'h12, 8'h07, 32'h01020304, 1'b0);
      send_range(0, 11);
      expect_out(K_ERR, 40'd0, last_e, "bad_rw");
      idle(3);

      // Corrupted CRC_L
      build_frame(16'h0001, 16'h0008, 8'h33, 8'h06, 32'hCAFEF00D, 1'b1);
      send_range(0, 11);
`ifdef RX_FRAME_CRC_CHECK_EN
      expect_out(K_ERR, 40'd2, last_e, "bad_crc");
`else
      expect_out(K_SEN, 40'h33_CAFEF00D, last_e, "crc_ignored");
`endif
      idle(3);

      // Timeout after 3 bytes
      build_frame(16'h0001, 16'h0008, 8'h44, 8'h06, 32'h10203040, 1'b0);
      send_range(0, 2);
      expect_out(K_ERR, 40'd3, last_e + GAP, "timeout");
      idle(GAP + 3);

      // Byte arriving in the expiry cycle keeps the frame alive
      send_range(0, 2);
      idle(GAP - 1);
      send_range(3, 11);
      expect_out(K_SEN, 40'h44_10203040, last_e, "byte_beats_timeout");
      idle(3);

      // Reset mid-payload
      build_frame(16'h0001, 16'h0008, 8'h55, 8'h06, 32'h99887766, 1'b0);
      send_range(0, 7);
      sys_rst = 1'b1;
      idle(2);
      chk("midrst_ret_cmd",      {32'h0, dut_if.ret_cmd}, 40'h0);
      chk("midrst_sen_cmd",      dut_if.sen_cmd, 40'h0);
      chk("midrst_frm_err_code", {38'h0, dut_if.frm_err_code}, 40'h0);
      chk("midrst_flags", {37'h0, dut_if.frm_err, dut_if.sen_cmd_flag, dut_if.ret_cmd_flg}, 40'h0);
      sys_rst = 1'b0;
      idle(2);
      send_range(0, 11);
      expect_out(K_SEN, 40'h55_99887766, last_e, "write_after_reset");
      idle(3);

      // Broadcast write accepted, broadcast read dropped
      build_frame(16'hFFFF, 16'h0008, 8'h66, 8'h06, 32'h0BADF00D, 1'b0);
      send_range(0, 11);
      expect_out(K_SEN, 40'h66_0BADF00D, last_e, "bcast_write");
      idle(3);
      build_frame(16'hFFFF, 16'h0008, 8'h77, 8'h03, 32'h00000000, 1'b0);
      send_range(0, 11);
      idle(3);
      build_frame(16'h0001, 16'h0008, 8'h78, 8'h03, 32'h00000000, 1'b0);
      send_range(0, 11);
      expect_out(K_RET, 40'h78, last_e, "read_after_bcast_read");

      idle(GAP + 5);
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         compared++;
         mismatched++;
         $display("FAIL %s actual=no_output required kind=%b data=%h cycle=%0d",
                  mon_e.name, mon_e.kind, mon_e.data, mon_e.at);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
